// File: rtl/div_controller_if.sv
// Request/result bundle between a divide requester and div_controller.
interface div_controller_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        ready;
    logic        busy;
    logic        exception;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, busy, exception
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, busy, exception
    );
endinterface

// File: rtl/div_controller.sv
// Sequencer for the 64-bit remainder/quotient register of the divide unit:
// loads |dividend|, runs 32 restoring shift-subtract steps, then signs the result.
module div_controller (
    input  logic             clk,
    input  logic             clr,
    div_controller_if.slave  req,
    input  logic [63:0]      rqb_q,
    output logic [31:0]      rqb_upper,
    output logic [31:0]      rqb_lower,
    output logic             rqb_ena
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] dmag_q, dmag_d;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic        div_zero;
    logic [63:0] shifted;
    logic [32:0] diff;

    // Magnitudes are 32-bit unsigned, so the most negative value maps onto itself.
    always_comb begin
        dividend_mag = req.dividend[31] ? -req.dividend : req.dividend;
        divisor_mag  = req.divisor[31]  ? -req.divisor  : req.divisor;
        div_zero     = (req.divisor == 32'd0);
        shifted      = rqb_q << 1;
        diff         = {1'b0, shifted[63:32]} - {1'b0, dmag_q};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        dmag_d    = dmag_q;
        rqb_ena   = 1'b0;
        rqb_upper = 32'd0;
        rqb_lower = 32'd0;

        case (state_q)
            IDLE: begin
                if (req.start) begin
                    rqb_ena   = 1'b1;
                    rqb_upper = 32'd0;
                    rqb_lower = div_zero ? 32'd0 : dividend_mag;
                    neg_quo_d = req.dividend[31] ^ req.divisor[31];
                    neg_rem_d = req.dividend[31];
                    dz_d      = div_zero;
                    dmag_d    = divisor_mag;
                    count_d   = 5'd0;
                    state_d   = div_zero ? DONE : ITER;
                end
            end
            ITER: begin
                rqb_ena = 1'b1;
                // A clear borrow bit means the trial subtraction fits: keep it and shift in a 1.
                if (!diff[32]) begin
                    rqb_upper = diff[31:0];
                    rqb_lower = {shifted[31:1], 1'b1};
                end else begin
                    rqb_upper = shifted[63:32];
                    rqb_lower = shifted[31:0];
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            dmag_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            dmag_q    <= dmag_d;
        end
    end

    // Results stay valid after DONE since the register is only written on loads and steps.
    always_comb begin
        req.quotient  = neg_quo_q ? -rqb_q[31:0]  : rqb_q[31:0];
        req.remainder = neg_rem_q ? -rqb_q[63:32] : rqb_q[63:32];
        req.ready     = (state_q == DONE);
        req.busy      = (state_q != IDLE);
        req.exception = dz_q;
    end

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller with a behavioural model of the
// remainder/quotient register and a plain-arithmetic reference divider.
module tb_div_controller;

    logic        clk;
    logic        clr;
    logic [31:0] rqb_upper;
    logic [31:0] rqb_lower;
    logic        rqb_ena;
    logic [63:0] rqb_q = 64'd0;

    int total = 0;
    int bad   = 0;

    div_controller_if bus ();

    div_controller dut (
        .clk       (clk),
        .clr       (clr),
        .req       (bus.slave),
        .rqb_q     (rqb_q),
        .rqb_upper (rqb_upper),
        .rqb_lower (rqb_lower),
        .rqb_ena   (rqb_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared register: not reset, written only when the controller enables it.
    always @(posedge clk) begin
        if (rqb_ena) rqb_q <= {rqb_upper, rqb_lower};
    end

    // Reference: signed division truncating toward zero on 32-bit magnitudes.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic exc, output int lat);
        logic [31:0] ua, ub, qm, rm;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; exc = 1'b1; lat = 1;
        end else begin
            ua = a[31] ? (~a + 32'd1) : a;
            ub = b[31] ? (~b + 32'd1) : b;
            qm = ua / ub;
            rm = ua % ub;
            q = (a[31] ^ b[31]) ? (~qm + 32'd1) : qm;
            r = a[31] ? (~rm + 32'd1) : rm;
            exc = 1'b0; lat = 33;
        end
    endfunction

    // Starts one divide and follows it to the ready pulse (bounded at 40 cycles).
    task automatic run_divide(input logic [31:0] a, input logic [31:0] b,
                              output int lat, output int ena_cnt,
                              output logic [31:0] q, output logic [31:0] r,
                              output logic exc);
        lat = 0; q = 32'hDEADBEEF; r = 32'hDEADBEEF; exc = 1'bx;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        #1;
        ena_cnt = rqb_ena ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
        for (int i = 1; i <= 40; i++) begin
            if (rqb_ena) ena_cnt++;
            if (bus.ready) begin
                lat = i; q = bus.quotient; r = bus.remainder; exc = bus.exception;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.ready, bus.exception, rqb_ena} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: busy/ready/exc/ena=%b required 0000",
                     {bus.busy, bus.ready, bus.exception, rqb_ena});
        end
        total++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            bad++;
            $display("FAIL reset_result: q=%h r=%h required 0 0", bus.quotient, bus.remainder);
        end
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rqb_ena !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet: ena=%b busy=%b required 0 0", rqb_ena, bus.busy);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'd9, 32'hFFFFFFF9};
        logic [31:0] tb [6] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFE};
        logic [31:0] tq [6] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'd3, 32'd3};
        logic [31:0] tr [6] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        int lat, ena_cnt;
        logic [31:0] q, r;
        logic exc;
        for (int k = 0; k < 6; k++) begin
            run_divide(ta[k], tb[k], lat, ena_cnt, q, r, exc);
            total++;
            if (lat !== 33 || ena_cnt !== 33) begin
                bad++;
                $display("FAIL directed_timing[%0d]: latency=%0d ena_edges=%0d required 33 33", k, lat, ena_cnt);
            end
            total++;
            if (q !== tq[k] || r !== tr[k] || exc !== 1'b0) begin
                bad++;
                $display("FAIL directed_result[%0d]: q=%h r=%h exc=%b required %h %h 0",
                         k, q, r, exc, tq[k], tr[k]);
            end
            @(negedge clk);
            total++;
            if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== tq[k] || bus.remainder !== tr[k]) begin
                bad++;
                $display("FAIL directed_hold[%0d]: ready=%b busy=%b q=%h r=%h required 0 0 %h %h",
                         k, bus.ready, bus.busy, bus.quotient, bus.remainder, tq[k], tr[k]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, ena_cnt;
        logic [31:0] q, r;
        logic exc;
        run_divide(32'd5, 32'd0, lat, ena_cnt, q, r, exc);
        total++;
        if (lat !== 1 || ena_cnt !== 1) begin
            bad++;
            $display("FAIL dz_timing: latency=%0d ena_edges=%0d required 1 1", lat, ena_cnt);
        end
        total++;
        if (q !== 32'd0 || r !== 32'd0 || exc !== 1'b1) begin
            bad++;
            $display("FAIL dz_result: q=%h r=%h exc=%b required 0 0 1", q, r, exc);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.exception !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL dz_held: exc=%b busy=%b required 1 0", bus.exception, bus.busy);
        end
        run_divide(32'd9, 32'd3, lat, ena_cnt, q, r, exc);
        total++;
        if (lat !== 33 || q !== 32'd3 || r !== 32'd0 || exc !== 1'b0) begin
            bad++;
            $display("FAIL dz_clear: latency=%0d q=%h r=%h exc=%b required 33 3 0 0", lat, q, r, exc);
        end
    endtask

    task automatic test_overlap_start();
        int lat = 0;
        logic [31:0] q = 32'hDEADBEEF, r = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == 10);
            if (i == 10) begin
                bus.dividend = 32'd1; bus.divisor = 32'd1;
            end
            if (bus.ready) begin
                lat = i; q = bus.quotient; r = bus.remainder;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        total++;
        if (lat !== 33 || q !== 32'd10 || r !== 32'd0) begin
            bad++;
            $display("FAIL overlap_start: latency=%0d q=%h r=%h required 33 a 0", lat, q, r);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lat, ena_cnt;
        logic [31:0] q, r;
        logic exc;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || rqb_ena !== 1'b1) begin
            bad++;
            $display("FAIL mid_running: busy=%b ena=%b required 1 1", bus.busy, rqb_ena);
        end
        clr = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.ready, bus.exception, rqb_ena} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_drop: busy/ready/exc/ena=%b required 0000",
                     {bus.busy, bus.ready, bus.exception, rqb_ena});
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rqb_ena !== 1'b0 || bus.ready !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_idle: ena=%b ready=%b required 0 0", rqb_ena, bus.ready);
            end
        end
        run_divide(32'd7, 32'd2, lat, ena_cnt, q, r, exc);
        total++;
        if (lat !== 33 || ena_cnt !== 33 || q !== 32'd3 || r !== 32'd1 || exc !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: latency=%0d ena_edges=%0d q=%h r=%h exc=%b required 33 33 3 1 0",
                     lat, ena_cnt, q, r, exc);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        logic exc, eexc;
        int lat, elat, ena_cnt;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            ref_div(a, b, eq, er, eexc, elat);
            run_divide(a, b, lat, ena_cnt, q, r, exc);
            total++;
            if (q !== eq || r !== er || exc !== eexc || lat !== elat) begin
                bad++;
                $display("FAIL random[%0d] %h/%h: q=%h r=%h exc=%b lat=%0d required %h %h %b %0d",
                         k, a, b, q, r, exc, lat, eq, er, eexc, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        logic [31:0] eq, er;
        logic eexc;
        int elat;
        ref_div(32'd1000, 32'hFFFFFFDF, eq, er, eexc, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'hFFFFFFDF;
        for (int i = 0; i < 120 && second < 0; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                total++;
                if (bus.quotient !== eq || bus.remainder !== er) begin
                    bad++;
                    $display("FAIL b2b_result: q=%h r=%h required %h %h", bus.quotient, bus.remainder, eq, er);
                end
                if (first < 0) first = i;
                else begin
                    second = i;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        total++;
        if (first !== 32 || second - first !== 34) begin
            bad++;
            $display("FAIL b2b_period: first_ready=%0d period=%0d required 32 34", first, second - first);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_overlap_start();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
